// File: rtl/ks_multibyte_add_seq_if.sv
// Operand/result handshake bundle for ks_multibyte_add_seq.
// Optional macro: KS_SEQ_SUBTRACT_EN adds the sub request signal.
interface ks_multibyte_add_seq_if #(
  parameter int unsigned NBYTES = 4
);
  localparam int unsigned W = 8 * NBYTES;

  // Operand side
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
`ifdef KS_SEQ_SUBTRACT_EN
  logic         sub;
`endif

  // Result side
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  // Producer/consumer view
  modport master (
`ifdef KS_SEQ_SUBTRACT_EN
    output sub,
`endif
    output in_valid,
    output op_a,
    output op_b,
    output cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout
  );

  // Sequencer view
  modport slave (
`ifdef KS_SEQ_SUBTRACT_EN
    input  sub,
`endif
    input  in_valid,
    input  op_a,
    input  op_b,
    input  cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout
  );
endinterface

// File: rtl/ks_multibyte_add_seq.sv
// Byte-serial NBYTES-wide adder built around one shared 8-bit Kogge-Stone adder.
// Bytes are processed LSB first; the byte carry is chained through carry_q.
// Optional macro: KS_SEQ_SUBTRACT_EN adds subtraction (A + ~B + 1) selected by sub.
module ks_multibyte_add_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ks_multibyte_add_seq_if.slave bus,
  output logic                 busy
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // 8-bit Kogge-Stone adder; carry-in folded into bit 0 generate so the
  // prefix tree directly yields the carry into every bit position.
  function automatic logic [8:0] ks_add8(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic       ci);
    logic [7:0] p0;
    logic [7:0] g;
    logic [7:0] p;
    logic [7:0] gn;
    logic [7:0] pn;
    logic [8:0] c;
    p0   = a ^ b;
    g    = a & b;
    g[0] = g[0] | (p0[0] & ci);
    p    = p0;
    for (int lvl = 0; lvl < 3; lvl++) begin
      for (int i = 0; i < 8; i++) begin
        if (i >= (1 << lvl)) begin
          gn[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
          pn[i] = p[i] & p[i - (1 << lvl)];
        end else begin
          gn[i] = g[i];
          pn[i] = p[i];
        end
      end
      g = gn;
      p = pn;
    end
    c = {g, ci};
    return {c[8], p0 ^ c[7:0]};
  endfunction

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
`ifdef KS_SEQ_SUBTRACT_EN
  logic            sub_q, sub_d;
`endif

  logic [7:0]      add_a;
  logic [7:0]      add_b;
  logic [8:0]      add_res;

  // Shared byte adder: current low bytes of the shift registers plus chained carry
  always_comb begin
    add_a = a_q[7:0];
`ifdef KS_SEQ_SUBTRACT_EN
    add_b = b_q[7:0] ^ {8{sub_q}};
`else
    add_b = b_q[7:0];
`endif
    add_res = ks_add8(add_a, add_b, carry_q);
  end

  // Next-state, datapath update and registered-output targets
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
`ifdef KS_SEQ_SUBTRACT_EN
    sub_d       = sub_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          idx_d   = '0;
          state_d = ST_RUN;
`ifdef KS_SEQ_SUBTRACT_EN
          sub_d   = bus.sub;
          carry_d = bus.sub ? 1'b1 : bus.cin;
`else
          carry_d = bus.cin;
`endif
        end
      end

      ST_RUN: begin
        sum_d[{idx_q, 3'b000} +: 8] = add_res[7:0];
        carry_d = add_res[8];
        a_d     = a_q >> 8;
        b_d     = b_q >> 8;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NBYTES - 1)) begin
          cout_d  = add_res[8];
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_RUN) || (state_d == ST_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef KS_SEQ_SUBTRACT_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef KS_SEQ_SUBTRACT_EN
      sub_q       <= sub_d;
`endif
    end
  end

  // Drive the bundle and status from flops
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign busy          = busy_q;

endmodule
